// File: rtl/fetch_line_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_line_ctrl
//
// Fetch-line controller for the IF stage. Keeps a single four-instruction
// line buffer keyed by the pc line address (pc[ADDR_LEN-1:4]) and presents
// it to the IF select logic. When the current pc misses the buffer while IF
// wants to fetch, it issues one req/gnt/rvalid line request to instruction
// memory and stalls IF until the line has been written. Redirects (flush)
// can withdraw a request that has not been granted yet. Buffer
// invalidation (inv, fence.i) drops any response that is still in flight.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   pc          current fetch pc
//   fetch_en    IF wants an instruction pair this cycle
//   flush       redirect; cancels an ungranted request
//   inv         invalidate the line buffer
//   idata       buffered line (LINE_W = 4*INSN_LEN bits)
//   line_hit    buffer valid and tag matches the pc line address
//   stall_if    fetch_en && !line_hit
//   mem_req     line request to imem
//   mem_addr    requested line address (ADDR_LEN-4 bits)
//   mem_gnt     imem accepts the request (only looked at while mem_req=1)
//   mem_rvalid  response valid, exactly one per grant
//   mem_rdata   response line
//   miss_cnt    saturating count of issued requests
// ---------------------------------------------------------------------------
module fetch_line_ctrl #(
    parameter int ADDR_LEN = 32,
    parameter int INSN_LEN = 32,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_LEN-1:0]       pc,
    input  logic                      fetch_en,
    input  logic                      flush,
    input  logic                      inv,
    output logic [4*INSN_LEN-1:0]     idata,
    output logic                      line_hit,
    output logic                      stall_if,
    output logic                      mem_req,
    output logic [ADDR_LEN-5:0]       mem_addr,
    input  logic                      mem_gnt,
    input  logic                      mem_rvalid,
    input  logic [4*INSN_LEN-1:0]     mem_rdata,
    output logic [CNT_W-1:0]          miss_cnt
);

    localparam int LINE_W = 4 * INSN_LEN;
    localparam int TAG_W  = ADDR_LEN - 4;

    // IDLE: no transaction; REQ: request on the bus waiting for a grant;
    // WAIT: granted, waiting for the data; DROP: granted, data unwanted.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_e;

    state_e              state_q;
    logic                buf_valid_q;
    logic [TAG_W-1:0]    buf_tag_q;
    logic [LINE_W-1:0]   buf_data_q;
    logic [TAG_W-1:0]    req_addr_q;
    logic                mem_req_q;
    logic [CNT_W-1:0]    miss_cnt_q;

    logic [TAG_W-1:0]    lineAddr;
    logic [CNT_W-1:0]    miss_cnt_d;
    logic                missStart_d;
    logic                unusedPcBits;

    // The byte/word offset inside the line never affects line selection.
    assign lineAddr     = pc[ADDR_LEN-1:4];
    assign unusedPcBits = ^pc[3:0];

    // Hit/stall are purely combinational: a line written at an edge is
    // visible from the following cycle, there is no bypass of mem_rdata.
    assign line_hit = buf_valid_q && (buf_tag_q == lineAddr);
    assign stall_if = fetch_en && !line_hit;
    assign idata    = buf_data_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = req_addr_q;
    assign miss_cnt = miss_cnt_q;

    // The counter sticks at all-ones instead of wrapping.
    assign miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : (miss_cnt_q + CNT_W'(1));

    // A new request is only started from a clean cycle: redirect and
    // invalidation both mean the current pc is not worth fetching yet.
    assign missStart_d = fetch_en && !line_hit && !flush && !inv;

    // Single FSM block holding the buffer, request registers and counter.
    // inv clears the valid bit in every state; the fill path below only
    // sets it when inv is low, so the two never fight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            req_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            miss_cnt_q  <= '0;
        end else begin
            if (inv) begin
                buf_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    // A stray mem_rvalid here is a protocol error and is
                    // deliberately ignored.
                    if (missStart_d) begin
                        req_addr_q <= lineAddr;
                        miss_cnt_q <= miss_cnt_d;
                        mem_req_q  <= 1'b1;
                        state_q    <= REQ;
                    end
                end

                REQ: begin
                    // Withdrawal wins over a same-cycle grant; the imem
                    // ignores a grant given together with a withdrawal.
                    if (flush || inv) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end

                WAIT: begin
                    // flush does not block the fill: the data is correct
                    // for req_addr regardless of where the pc went.
                    if (mem_rvalid) begin
                        if (!inv) begin
                            buf_valid_q <= 1'b1;
                            buf_tag_q   <= req_addr_q;
                            buf_data_q  <= mem_rdata;
                        end
                        state_q <= IDLE;
                    end else if (inv) begin
                        state_q <= DROP;
                    end
                end

                DROP: begin
                    // Hold off new requests until the owed response has
                    // been consumed, so only one is ever outstanding.
                    if (mem_rvalid) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_line_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_line_ctrl
//
// Directed bench for fetch_line_ctrl. A transaction-level model (buffer
// contents plus "request pending" / "response owed" / "discard" flags)
// predicts every output; a negedge process compares the DUT against it each
// cycle. The directed flow adds literal expectations worked out by hand.
// The counter is built narrow so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_fetch_line_ctrl;

    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam logic [127:0] P1   = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [127:0] P2   = 128'h8888_8888_7777_7777_6666_6666_5555_5555;
    localparam logic [127:0] P3   = 128'hCCCC_CCCC_BBBB_BBBB_AAAA_AAAA_9999_9999;
    localparam logic [127:0] P4   = 128'h0404_0404_0303_0303_0202_0202_0101_0101;
    localparam logic [127:0] JUNK = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    logic          clk;
    logic          reset;
    logic [31:0]   pc;
    logic          fetch_en;
    logic          flush;
    logic          inv;
    logic [127:0]  idata;
    logic          line_hit;
    logic          stall_if;
    logic          mem_req;
    logic [27:0]   mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [127:0]  mem_rdata;
    logic [CW-1:0] miss_cnt;

    int total = 0;
    int bad   = 0;

    fetch_line_ctrl #(
        .ADDR_LEN(32),
        .INSN_LEN(32),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .fetch_en  (fetch_en),
        .flush     (flush),
        .inv       (inv),
        .idata     (idata),
        .line_hit  (line_hit),
        .stall_if  (stall_if),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .miss_cnt  (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model state.
    logic          mValid;
    logic [27:0]   mTag;
    logic [127:0]  mData;
    logic [27:0]   mReqAddr;
    logic          mReqPending;
    logic          mRespOwed;
    logic          mDiscard;
    int            mCnt;

    // Model update: one outstanding transaction, described as "a request is
    // on the bus" and "a response is still owed (and maybe unwanted)".
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mValid      <= 1'b0;
            mTag        <= '0;
            mData       <= '0;
            mReqAddr    <= '0;
            mReqPending <= 1'b0;
            mRespOwed   <= 1'b0;
            mDiscard    <= 1'b0;
            mCnt        <= 0;
        end else begin
            if (mReqPending) begin
                if (flush || inv) begin
                    mReqPending <= 1'b0;
                end else if (mem_gnt) begin
                    mReqPending <= 1'b0;
                    mRespOwed   <= 1'b1;
                    mDiscard    <= 1'b0;
                end
            end else if (mRespOwed) begin
                if (mem_rvalid) begin
                    mRespOwed <= 1'b0;
                    if (!mDiscard && !inv) begin
                        mValid <= 1'b1;
                        mTag   <= mReqAddr;
                        mData  <= mem_rdata;
                    end
                end else if (inv) begin
                    mDiscard <= 1'b1;
                end
            end else if (fetch_en && !(mValid && mTag == pc[31:4]) && !flush && !inv) begin
                mReqPending <= 1'b1;
                mReqAddr    <= pc[31:4];
                mCnt        <= (mCnt < CNT_MAX) ? mCnt + 1 : CNT_MAX;
            end
            if (inv) begin
                mValid <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic expHit;
        expHit = mValid && (mTag == pc[31:4]);
        checkOutput("model.mem_req",  128'(mem_req),  128'(mReqPending));
        checkOutput("model.mem_addr", 128'(mem_addr), 128'(mReqAddr));
        checkOutput("model.line_hit", 128'(line_hit), 128'(expHit));
        checkOutput("model.stall_if", 128'(stall_if), 128'(fetch_en && !expHit));
        checkOutput("model.idata",    idata,          mData);
        checkOutput("model.miss_cnt", 128'(miss_cnt), 128'(mCnt));
    end

    task automatic applyStimulus(input logic fe, input logic [31:0] p, input logic fl,
                                 input logic iv, input logic g, input logic rv,
                                 input logic [127:0] rd);
        fetch_en   = fe;
        pc         = p;
        flush      = fl;
        inv        = iv;
        mem_gnt    = g;
        mem_rvalid = rv;
        mem_rdata  = rd;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0;
        applyStimulus(1, 32'h100, 0, 0, 0, 0, '0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.mem_req",  128'(mem_req),  128'(0));
        checkOutput("rst.miss_cnt", 128'(miss_cnt), 128'(0));
        checkOutput("rst.line_hit", 128'(line_hit), 128'(0));
        checkOutput("rst.idata",    idata,          128'(0));
        checkOutput("rst.mem_addr", 128'(mem_addr), 128'(0));
        checkOutput("rst.stall_if", 128'(stall_if), 128'(1));
        reset = 1'b1;
        $display("[TB] cold miss");
        tick;                                                // -> REQ
        applyStimulus(1, 32'h100, 0, 0, 1, 0, '0);
        checkOutput("cold.mem_req",  128'(mem_req),  128'(1));
        checkOutput("cold.mem_addr", 128'(mem_addr), 128'(28'h10));
        checkOutput("cold.miss_cnt", 128'(miss_cnt), 128'(1));
        tick;                                                // -> WAIT
        applyStimulus(1, 32'h100, 0, 0, 0, 0, '0);
        checkOutput("cold.wait_req", 128'(mem_req), 128'(0));
        tick;
        applyStimulus(1, 32'h100, 0, 0, 0, 1, P1);
        checkOutput("cold.stall",    128'(stall_if), 128'(1));
        tick;                                                // filled
        applyStimulus(1, 32'h100, 0, 0, 0, 0, '0);
        checkOutput("cold.hit",      128'(line_hit), 128'(1));
        checkOutput("cold.idata",    idata,          P1);
        checkOutput("cold.nostall",  128'(stall_if), 128'(0));
        tick;

        $display("[TB] hit sequence");
        applyStimulus(1, 32'h104, 0, 0, 0, 0, '0); tick;
        applyStimulus(1, 32'h108, 0, 0, 0, 0, '0); tick;
        applyStimulus(1, 32'h10C, 0, 0, 0, 0, '0);
        checkOutput("hits.hit",      128'(line_hit), 128'(1));
        checkOutput("hits.noreq",    128'(mem_req),  128'(0));
        tick;
        applyStimulus(1, 32'h110, 0, 0, 0, 0, '0);
        checkOutput("miss2.stall",   128'(stall_if), 128'(1));
        tick;
        applyStimulus(1, 32'h110, 0, 0, 1, 0, '0);
        checkOutput("miss2.mem_addr", 128'(mem_addr), 128'(28'h11));
        checkOutput("miss2.miss_cnt", 128'(miss_cnt), 128'(2));
        tick;
        applyStimulus(1, 32'h110, 0, 0, 0, 1, P2); tick;
        applyStimulus(1, 32'h110, 0, 0, 0, 0, '0);
        checkOutput("miss2.idata",   idata, P2);
        tick;

        $display("[TB] flush in REQ");
        applyStimulus(1, 32'h180, 0, 0, 0, 0, '0); tick;
        applyStimulus(1, 32'h180, 0, 0, 0, 0, '0);
        checkOutput("flush.mem_addr", 128'(mem_addr), 128'(28'h18));
        tick;
        applyStimulus(1, 32'h180, 1, 0, 0, 0, '0);
        checkOutput("flush.req_held", 128'(mem_req), 128'(1));
        tick;
        applyStimulus(1, 32'h200, 0, 0, 0, 0, '0);
        checkOutput("flush.req_gone", 128'(mem_req),  128'(0));
        checkOutput("flush.miss_cnt", 128'(miss_cnt), 128'(3));
        tick;
        applyStimulus(1, 32'h200, 0, 0, 1, 0, '0);
        checkOutput("flush.new_addr", 128'(mem_addr), 128'(28'h20));
        checkOutput("flush.new_cnt",  128'(miss_cnt), 128'(4));
        tick;

        $display("[TB] inv during WAIT");
        applyStimulus(1, 32'h110, 0, 0, 0, 0, '0);
        checkOutput("inv.prehit", 128'(line_hit), 128'(1));
        tick;
        applyStimulus(1, 32'h110, 0, 1, 0, 0, '0); tick;
        applyStimulus(1, 32'h110, 0, 0, 0, 0, '0);
        checkOutput("inv.hit_gone", 128'(line_hit), 128'(0));
        checkOutput("inv.drop_req", 128'(mem_req),  128'(0));
        tick;
        applyStimulus(1, 32'h110, 0, 0, 0, 0, '0); tick;
        applyStimulus(1, 32'h110, 0, 0, 0, 1, JUNK);
        checkOutput("inv.drop_req2", 128'(mem_req), 128'(0));
        tick;
        applyStimulus(1, 32'h110, 0, 0, 0, 0, '0);
        checkOutput("inv.not_written", idata, P2);
        checkOutput("inv.after_req",   128'(mem_req), 128'(0));
        tick;
        applyStimulus(1, 32'h110, 0, 0, 1, 0, '0);
        checkOutput("inv.rereq_addr", 128'(mem_addr), 128'(28'h11));
        checkOutput("inv.rereq_cnt",  128'(miss_cnt), 128'(5));
        tick;

        $display("[TB] simultaneous events");
        applyStimulus(1, 32'h110, 1, 0, 0, 1, P3); tick;
        applyStimulus(1, 32'h110, 0, 0, 0, 0, '0);
        checkOutput("rvflush.hit",   128'(line_hit), 128'(1));
        checkOutput("rvflush.idata", idata, P3);
        tick;
        applyStimulus(1, 32'h300, 0, 0, 0, 0, '0); tick;
        applyStimulus(1, 32'h300, 1, 0, 1, 0, '0); tick;
        applyStimulus(1, 32'h300, 0, 0, 0, 0, '0);
        checkOutput("gntflush.req", 128'(mem_req),  128'(0));
        checkOutput("gntflush.cnt", 128'(miss_cnt), 128'(6));
        tick;
        applyStimulus(1, 32'h300, 0, 0, 1, 0, '0); tick;
        applyStimulus(1, 32'h110, 0, 1, 0, 1, JUNK); tick;
        applyStimulus(0, 32'h110, 0, 0, 0, 0, '0);
        checkOutput("rvinv.hit",   128'(line_hit), 128'(0));
        checkOutput("rvinv.idata", idata, P3);
        tick;
        applyStimulus(0, 32'h110, 0, 0, 0, 1, JUNK); tick;
        applyStimulus(0, 32'h110, 0, 0, 0, 0, '0);
        checkOutput("stray.idata", idata, P3);
        tick;

        $display("[TB] saturation");
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            applyStimulus(1, 32'h400, 0, 0, 0, 0, '0); tick;
            applyStimulus(1, 32'h400, 1, 0, 0, 0, '0); tick;
        end
        applyStimulus(1, 32'h400, 0, 0, 0, 0, '0);
        checkOutput("sat.cnt", 128'(miss_cnt), 128'(4'hF));
        tick;
        applyStimulus(1, 32'h400, 0, 0, 1, 0, '0);
        checkOutput("sat.cnt_hold", 128'(miss_cnt), 128'(4'hF));
        tick;
        applyStimulus(1, 32'h400, 0, 0, 0, 1, P4); tick;
        applyStimulus(1, 32'h500, 0, 0, 0, 0, '0);
        checkOutput("sat.idata", idata, P4);
        tick;
        applyStimulus(1, 32'h500, 0, 0, 1, 0, '0); tick;

        $display("[TB] async reset in WAIT");
        applyStimulus(1, 32'h400, 0, 0, 0, 0, '0);
        checkOutput("arst.prehit",    128'(line_hit), 128'(1));
        checkOutput("arst.pre_addr",  128'(mem_addr), 128'(28'h50));
        reset = 1'b0;
        #1;
        checkOutput("arst.line_hit", 128'(line_hit), 128'(0));
        checkOutput("arst.idata",    idata,          128'(0));
        checkOutput("arst.miss_cnt", 128'(miss_cnt), 128'(0));
        checkOutput("arst.mem_addr", 128'(mem_addr), 128'(0));
        checkOutput("arst.mem_req",  128'(mem_req),  128'(0));
        checkOutput("arst.stall_if", 128'(stall_if), 128'(1));
        tick;
        tick;
        reset = 1'b1;
        tick;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_line_ctrl.md
Name: fetch_line_ctrl

Overview:
Fetch-line controller that sequences instruction-memory accesses for the IF stage. It holds a one-line (4-instruction) buffer keyed by pc line address and drives idata into the IF select logic. On a miss it issues a req/gnt/rvalid line request to instruction memory and stalls IF until the line is filled. It also handles redirect cancellation and buffer invalidation (fence.i) with in-flight response dropping.

Parameters:
ADDR_LEN, 32, byte address width
INSN_LEN, 32, instruction width; line width LINE_W = 4*INSN_LEN
CNT_W, 16, width of saturating miss counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
pc  input  ADDR_LEN  current fetch pc; line address = pc[ADDR_LEN-1:4]
fetch_en  input  1  IF wants an instruction pair this cycle
flush  input  1  redirect (prmiss); cancels an ungranted request
inv  input  1  invalidate line buffer (fence.i)
idata  output  LINE_W  buffered line to select logic
line_hit  output  1  buffer valid and tag == pc[ADDR_LEN-1:4]
stall_if  output  1  fetch_en && !line_hit
mem_req  output  1  line request to imem
mem_addr  output  ADDR_LEN-4  requested line address
mem_gnt  input  1  imem accepts request this cycle (sampled only while mem_req=1)
mem_rvalid  input  1  response data valid; exactly one per grant, at least 1 cycle after gnt
mem_rdata  input  LINE_W  response line
miss_cnt  output  CNT_W  number of requests issued, saturating

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, buf_valid=0, buf_tag=0, buf_data=0 (idata=0), req_addr=0 (mem_addr=0), mem_req=0, miss_cnt=0, line_hit=0. stall_if stays combinational (=fetch_en while buffer invalid).
- line_hit, stall_if, idata: combinational from buffer and pc. No bypass: a filled line hits the cycle after mem_rvalid.
- FSM states: IDLE, REQ, WAIT, DROP.
- IDLE: if fetch_en && !line_hit && !flush && !inv, then req_addr<=pc[ADDR_LEN-1:4], miss_cnt++ (saturate at all-ones), ->REQ. Otherwise stay.
- REQ: mem_req=1, mem_addr=req_addr.
  - flush or inv -> IDLE; request withdrawn next cycle, even if mem_gnt is high the same cycle. The flush/inv check takes priority over the grant, and the imem ignores a gnt given together with a withdrawal.
  - Otherwise mem_gnt=1 -> WAIT.
- WAIT: mem_req=0.
  - mem_rvalid && !inv: buf_valid<=1, buf_tag<=req_addr, buf_data<=mem_rdata, ->IDLE. flush does not block the fill; the line is correct for its tag.
  - mem_rvalid && inv: discard data, buf_valid<=0, ->IDLE.
  - inv && !mem_rvalid: ->DROP.
- DROP: mem_req=0; on mem_rvalid discard data, ->IDLE. No new request until the response has arrived.
- inv in any state clears buf_valid at the next edge; line_hit is 0 from the following cycle.
- Only one request is outstanding at a time. pc may change while in REQ or WAIT; the fill still targets req_addr, and hit/miss is re-evaluated in IDLE.
- Miss to fill latency with gnt in the first REQ cycle and rvalid 1 cycle later: miss at cycle 0, REQ at 1, WAIT at 2, fill edge at end of 2, hit at 3.
- mem_rvalid outside WAIT/DROP is a protocol error; it is ignored and the buffer is left unchanged.
- Reset asserted mid-request returns to IDLE immediately. The imem is reset by the same signal, so no stale response follows.

Test Plan:
- Cold miss: reset release, pc=0x100, fetch_en=1, gnt in 1st REQ cycle, rvalid 2 cycles later with rdata=0x4444_3333_2222_1111 pattern. Required: mem_req=1 with mem_addr=0x10, stall_if=1 until fill, line_hit=1 and idata=pattern the next cycle, miss_cnt=1.
- Hit/miss sequence: after fill, pc 0x104, then 0x108, then 0x10C. Required: no requests. Then pc=0x110: new request with mem_addr=0x11 and miss_cnt=2.
- Flush in REQ with gnt held low for 3 cycles, flush on cycle 2. Required: mem_req drops next cycle, state IDLE, miss_cnt unchanged by the flush; a new miss to pc=0x200 issues mem_addr=0x20.
- inv during WAIT, rvalid 3 cycles later. Required: DROP entered, returned data not written, line_hit=0, no mem_req until after rvalid, then the re-request for the same line.
- Simultaneous events: rvalid together with flush (buffer filled, hit next cycle); rvalid together with inv (buffer invalid); gnt together with flush in REQ (withdrawn, back to IDLE).
- Saturation and async reset: force 2^CNT_W+3 misses, miss_cnt holds 0xFFFF. Assert reset while in WAIT: all outputs return to reset values immediately, without waiting for a clock edge.
